// File: rtl/zueirai_mem_arbiter.sv
// zueirai_mem_arbiter: two-port arbiter sharing the ZueiraI paged data memory; define ZUEIRAI_ARB_ROUND_ROBIN_EN for round-robin arbitration
module zueirai_mem_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [1:0]  page0,
  input  logic [7:0]  addr0,
  input  logic [7:0]  wdata0,
  output logic        gnt0,
  output logic        ack0,
  input  logic        req1,
  input  logic        we1,
  input  logic [1:0]  page1,
  input  logic [7:0]  addr1,
  input  logic [7:0]  wdata1,
  output logic        gnt1,
  output logic        ack1,
  output logic [7:0]  rdata,
  output logic [11:0] ctrl_MEM,
  output logic [7:0]  out_MEM,
  input  logic [7:0]  in_MEM,
  output logic        busy
);
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] lat_cnt;
  logic take, pick, win, we_l;
  logic [1:0] page_l;
  logic [7:0] addr_l, wdata_l;
  assign take = state == IDLE && (req0 || req1);
`ifdef ZUEIRAI_ARB_ROUND_ROBIN_EN
  logic last_gnt;
  assign pick = req0 && req1 ? !last_gnt : req1;
  always_ff @(posedge clk)
    if (rst) last_gnt <= 1'b1;
    else if (take) last_gnt <= pick;
`else
  assign pick = !req0;
`endif
  always_comb begin
    state_n = IDLE;
    if (take) state_n = ACCESS;
    else if (state == ACCESS) state_n = lat_cnt == '0 ? DONE : ACCESS;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // Outputs trail the state by one cycle: gnt, MEM_LAT strobe cycles, then ack with data
  always_ff @(posedge clk) begin
    if (rst) begin
      {gnt0, gnt1, ack0, ack1, busy} <= '0;
      rdata <= '0;
      ctrl_MEM <= '0;
      out_MEM <= '0;
      lat_cnt <= '0;
      {win, we_l, page_l, addr_l, wdata_l} <= '0;
    end else begin
      gnt0 <= take && !pick;
      gnt1 <= take && pick;
      ack0 <= state == DONE && !win;
      ack1 <= state == DONE && win;
      busy <= state != IDLE || state_n != IDLE;
      ctrl_MEM <= state == ACCESS ? {we_l, !we_l, page_l, addr_l} : '0;
      out_MEM <= state == ACCESS && we_l ? wdata_l : '0;
      if (state == DONE && !we_l) rdata <= in_MEM;
      if (take) begin
        {win, we_l, page_l, addr_l, wdata_l} <= pick ? {1'b1, we1, page1, addr1, wdata1}
                                                     : {1'b0, we0, page0, addr0, wdata0};
        lat_cnt <= CW'(MEM_LAT - 1);
      end else if (state == ACCESS && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
    end
  end
endmodule
